// File: rtl/irq_exc_pkg.sv
// Shared types and constants for the interrupt/exception controller.
// CAUSE layout: [31] exception flag, [12:8] interrupt channel, [2:0] cause code.
package irq_exc_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CSR_MASK    = 2'd0,
        CSR_PENDING = 2'd1,
        CSR_CAUSE   = 2'd2,
        CSR_EPC     = 2'd3
    } csr_addr_e;

    localparam logic [2:0] CODE_IRQ    = 3'd0;
    localparam logic [2:0] CODE_OVF    = 3'd1;
    localparam logic [2:0] CODE_ILL    = 3'd2;
    localparam logic [2:0] CODE_FETCH  = 3'd3;
    localparam logic [2:0] CODE_PRIV   = 3'd4;
    localparam logic [2:0] CODE_DFAULT = 3'd5;

    localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h8000_0008;

    function automatic logic [31:0] make_cause(input logic       is_exc,
                                               input logic [4:0] chan,
                                               input logic [2:0] code);
        logic [31:0] c;
        c        = '0;
        c[31]    = is_exc;
        c[12:8]  = chan;
        c[2:0]   = code;
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module irq_prio_enc #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Scan downward so the lowest set index is the last assignment and wins.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller for the single-cycle MIPS core: edge-latched
// maskable IRQs, prioritised exceptions, EPC/CAUSE CSRs and double-fault halt.
module irq_exc_ctrl
    import irq_exc_pkg::*;
#(
    parameter int          NUM_IRQ = 4,
    parameter int          NUM_EXC = 3,
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEFAULT,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    input  logic [31:0]        pc_next_in,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_EXC-1:0] exc_in,
    input  logic               eret,
    input  logic               csr_rd,
    input  logic               csr_wr,
    input  logic [1:0]         csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic [31:0]        pc_out,
    output logic [31:0]        epc,
    output logic               in_handler,
    output logic               halted
);

    localparam int IRQ_IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int EXC_W  = NUM_EXC + 1;
    localparam int EXC_IW = (EXC_W > 1) ? $clog2(EXC_W) : 1;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        cause_q, cause_d;
    logic               shadow_q, shadow_d;

    logic               priv_viol;
    logic               exc_req, irq_any, irq_req;
    logic [EXC_IW-1:0]  exc_idx;
    logic [IRQ_IW-1:0]  irq_idx;
    logic [2:0]         exc_code;
    logic               take_exc, take_irq, dfault, do_eret;
    logic [NUM_IRQ-1:0] irq_set, irq_clr;
    logic               csr_wr_mask, csr_wr_pend, csr_wr_epc;

    // Privilege violation sits above exc_in so it loses to every external source.
    assign priv_viol = ~pc[31] & pc_next_in[31] & (state_q == ST_RUN);

    irq_prio_enc #(.W(EXC_W), .IW(EXC_IW)) u_exc_enc (
        .req_i   ({priv_viol, exc_in}),
        .idx_o   (exc_idx),
        .valid_o (exc_req)
    );

    irq_prio_enc #(.W(NUM_IRQ), .IW(IRQ_IW)) u_irq_enc (
        .req_i   (pending_q & mask_q),
        .idx_o   (irq_idx),
        .valid_o (irq_any)
    );

    assign irq_req  = (state_q == ST_RUN) & irq_any & ~shadow_q;
    assign exc_code = (exc_idx == EXC_IW'(NUM_EXC)) ? CODE_PRIV : (3'(exc_idx) + 3'd1);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (exc_req || irq_req) state_d = ST_HANDLER;
            ST_HANDLER: if (exc_req)            state_d = ST_HALT;
                        else if (eret)          state_d = ST_RUN;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_RUN;
        endcase
    end

    // FSM: outputs and take strobes
    always_comb begin
        pc_out     = pc_next_in;
        take_exc   = 1'b0;
        take_irq   = 1'b0;
        dfault     = 1'b0;
        do_eret    = 1'b0;
        in_handler = (state_q == ST_HANDLER);
        halted     = (state_q == ST_HALT);
        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    take_exc = 1'b1;
                    pc_out   = EXC_VEC;
                end else if (irq_req) begin
                    take_irq = 1'b1;
                    pc_out   = IRQ_VEC;
                end
            end
            ST_HANDLER: begin
                if (exc_req) begin
                    dfault = 1'b1;
                    pc_out = pc;
                end else if (eret) begin
                    do_eret = 1'b1;
                    pc_out  = epc_q;
                end
            end
            ST_HALT: pc_out = pc;
            default: pc_out = pc_next_in;
        endcase
    end

    assign csr_wr_mask = csr_wr & (csr_addr == CSR_MASK);
    assign csr_wr_pend = csr_wr & (csr_addr == CSR_PENDING);
    assign csr_wr_epc  = csr_wr & (csr_addr == CSR_EPC);

    assign irq_set = irq_in & ~irq_prev_q;

    always_comb begin
        irq_clr = '0;
        if (take_irq) irq_clr = NUM_IRQ'(1) << irq_idx;
        if (csr_wr_pend && state_q != ST_HALT) irq_clr = irq_clr | csr_wdata[NUM_IRQ-1:0];
        // A fresh edge overrides a same-cycle clear of that bit.
        pending_d = (pending_q & ~irq_clr) | irq_set;
    end

    always_comb begin
        mask_d   = csr_wr_mask ? csr_wdata[NUM_IRQ-1:0] : mask_q;
        epc_d    = csr_wr_epc ? csr_wdata : epc_q;
        cause_d  = cause_q;
        shadow_d = do_eret;
        if (take_exc) begin
            epc_d   = pc;
            cause_d = make_cause(1'b1, 5'd0, exc_code);
        end else if (take_irq) begin
            epc_d   = pc_next_in;
            cause_d = make_cause(1'b0, 5'(irq_idx), CODE_IRQ);
        end else if (dfault) begin
            cause_d = make_cause(1'b1, 5'd0, CODE_DFAULT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            mask_q     <= '0;
            irq_prev_q <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
            shadow_q   <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_prev_q <= irq_in;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            shadow_q   <= shadow_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_rd) begin
            case (csr_addr)
                CSR_MASK:    csr_rdata = 32'(mask_q);
                CSR_PENDING: csr_rdata = 32'(pending_q);
                CSR_CAUSE:   csr_rdata = cause_q;
                default:     csr_rdata = epc_q;
            endcase
        end
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Scoreboard bench for irq_exc_ctrl: directed scenarios plus random idle PCs.
module tb_irq_exc_ctrl;

    localparam int          NUM_IRQ = 4;
    localparam int          NUM_EXC = 3;
    localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC = 32'h8000_0008;
    localparam logic [1:0]  A_MASK = 2'd0, A_PEND = 2'd1, A_CAUSE = 2'd2, A_EPC = 2'd3;

    logic               clk, reset;
    logic [31:0]        pc, pc_next_in;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_EXC-1:0] exc_in;
    logic               eret, csr_rd, csr_wr;
    logic [1:0]         csr_addr;
    logic [31:0]        csr_wdata, csr_rdata, pc_out, epc;
    logic               in_handler, halted;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rv;

    irq_exc_ctrl #(.NUM_IRQ(NUM_IRQ), .NUM_EXC(NUM_EXC), .IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_next_in(pc_next_in),
        .irq_in(irq_in), .exc_in(exc_in), .eret(eret),
        .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .pc_out(pc_out), .epc(epc), .in_handler(in_handler), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected nothing (queue empty)", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        csr_rd   = 1'b1;
        csr_addr = a;
        #1;
        d        = csr_rdata;
        csr_rd   = 1'b0;
        csr_addr = 2'd0;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        csr_wr    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_wr    = 1'b0;
        csr_addr  = 2'd0;
        csr_wdata = '0;
    endtask

    task automatic sb(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push_exp(exp);
        pop_check(tag, obs);
    endtask

    initial begin
        reset = 1'b0; pc = '0; pc_next_in = '0; irq_in = '0; exc_in = '0;
        eret = 1'b0; csr_rd = 1'b0; csr_wr = 1'b0; csr_addr = '0; csr_wdata = '0;

        // Reset state
        #1;
        sb("rst_pc_out", pc_out, 32'h0);
        sb("rst_epc", epc, 32'h0);
        sb("rst_halted", 32'(halted), 32'h0);
        sb("rst_in_handler", 32'(in_handler), 32'h0);
        csr_read(A_MASK, rv);  sb("rst_mask", rv, 32'h0);
        csr_read(A_PEND, rv);  sb("rst_pending", rv, 32'h0);
        csr_read(A_CAUSE, rv); sb("rst_cause", rv, 32'h0);
        repeat (2) tick();
        reset = 1'b1; pc = 32'h10; pc_next_in = 32'h14;
        tick();

        // Masked channel 2 interrupt
        csr_write(A_MASK, 32'h6);
        csr_read(A_MASK, rv); sb("t1_mask_rd", rv, 32'h6);
        pc = 32'hFC; pc_next_in = 32'h100; irq_in = 4'b0100;
        tick();
        irq_in = '0;
        #1;
        sb("t1_vec", pc_out, IRQ_VEC);
        csr_read(A_PEND, rv); sb("t1_pend_set", rv, 32'h4);
        push_exp(32'h100); push_exp(32'h200);
        tick();
        pop_check("t1_epc", epc);
        csr_read(A_CAUSE, rv); pop_check("t1_cause", rv);
        csr_read(A_PEND, rv);  sb("t1_pend_clr", rv, 32'h0);
        sb("t1_in_handler", 32'(in_handler), 32'h1);
        eret = 1'b1;
        #1;
        sb("t1_eret_pc", pc_out, 32'h100);
        tick();
        eret = 1'b0; pc_next_in = 32'h104;
        #1;
        sb("t1_back_run", 32'(in_handler), 32'h0);
        sb("t1_run_pc", pc_out, 32'h104);

        // Two simultaneous edges, shadow cycle between handlers
        csr_write(A_MASK, 32'hF);
        irq_in = 4'b1010;
        tick();
        pc_next_in = 32'h200;
        #1;
        sb("t2_vec1", pc_out, IRQ_VEC);
        push_exp(32'h200); push_exp(32'h100);
        tick();
        pop_check("t2_epc1", epc);
        csr_read(A_CAUSE, rv); pop_check("t2_cause1", rv);
        csr_read(A_PEND, rv);  sb("t2_pend_left", rv, 32'h8);
        eret = 1'b1;
        #1;
        sb("t2_eret_pc", pc_out, 32'h200);
        tick();
        eret = 1'b0; pc_next_in = 32'h204;
        #1;
        sb("t2_shadow", pc_out, 32'h204);
        tick();
        pc_next_in = 32'h208;
        #1;
        sb("t2_vec3", pc_out, IRQ_VEC);
        push_exp(32'h208); push_exp(32'h300);
        tick();
        pop_check("t2_epc3", epc);
        csr_read(A_CAUSE, rv); pop_check("t2_cause3", rv);
        eret = 1'b1;
        tick();
        eret = 1'b0; irq_in = '0;
        tick();

        // Exception beats an enabled pending interrupt
        irq_in = 4'b0001;
        tick();
        pc = 32'h40; pc_next_in = 32'h44; exc_in = 3'b001;
        #1;
        sb("t3_exc_vec", pc_out, EXC_VEC);
        push_exp(32'h40); push_exp(32'h8000_0001);
        tick();
        exc_in = '0;
        pop_check("t3_epc", epc);
        csr_read(A_CAUSE, rv); pop_check("t3_cause", rv);
        csr_read(A_PEND, rv);  sb("t3_irq_kept", rv, 32'h1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        #1;
        sb("t3_shadow", pc_out, 32'h44);
        tick();
        sb("t3_irq0_vec", pc_out, IRQ_VEC);
        push_exp(32'h44); push_exp(32'h0);
        tick();
        pop_check("t3_irq0_epc", epc);
        csr_read(A_CAUSE, rv); pop_check("t3_irq0_cause", rv);
        eret = 1'b1;
        tick();
        eret = 1'b0; irq_in = '0;
        tick();

        // Privilege violation only in RUN
        pc = 32'h20; pc_next_in = 32'h8000_0010;
        #1;
        sb("t4_priv_vec", pc_out, EXC_VEC);
        push_exp(32'h20); push_exp(32'h8000_0004);
        tick();
        pop_check("t4_priv_epc", epc);
        csr_read(A_CAUSE, rv); pop_check("t4_priv_cause", rv);
        sb("t4_hdl_no_priv", pc_out, 32'h8000_0010);
        tick();
        sb("t4_still_hdl", 32'(in_handler), 32'h1);
        sb("t4_not_halted", 32'(halted), 32'h0);
        eret = 1'b1; pc = 32'h10; pc_next_in = 32'h14;
        tick();
        eret = 1'b0;
        tick();

        // Double fault, halt, reset recovery
        pc = 32'h60; exc_in = 3'b100;
        #1;
        sb("t5_fetch_vec", pc_out, EXC_VEC);
        push_exp(32'h8000_0003);
        tick();
        csr_read(A_CAUSE, rv); pop_check("t5_fetch_cause", rv);
        exc_in = 3'b010; pc = 32'h64;
        #1;
        sb("t5_df_pc", pc_out, 32'h64);
        push_exp(32'h8000_0005);
        tick();
        exc_in = '0;
        csr_read(A_CAUSE, rv); pop_check("t5_df_cause", rv);
        sb("t5_halted", 32'(halted), 32'h1);
        sb("t5_epc_hold", epc, 32'h60);
        pc = 32'h68; eret = 1'b1; irq_in = 4'b0010;
        #1;
        sb("t5_halt_pc", pc_out, 32'h68);
        tick();
        eret = 1'b0;
        sb("t5_eret_ignored", 32'(halted), 32'h1);
        csr_write(A_PEND, 32'hF);
        csr_read(A_PEND, rv); sb("t5_halt_noclr", rv, 32'h2);
        reset = 1'b0;
        #1;
        sb("t5_rst_halted", 32'(halted), 32'h0);
        sb("t5_rst_in_handler", 32'(in_handler), 32'h0);
        sb("t5_rst_epc", epc, 32'h0);
        csr_read(A_CAUSE, rv); sb("t5_rst_cause", rv, 32'h0);
        csr_read(A_PEND, rv);  sb("t5_rst_pend", rv, 32'h0);
        csr_read(A_MASK, rv);  sb("t5_rst_mask", rv, 32'h0);
        tick();
        irq_in = '0; pc = 32'h10; pc_next_in = 32'h14;
        #2;
        reset = 1'b1;
        tick();

        // CSR behaviour: set beats W1C, mask width, EPC write, idle read
        irq_in = 4'b1110;
        tick();
        irq_in = 4'b1111;
        csr_write(A_PEND, 32'hF);
        csr_read(A_PEND, rv); sb("t6_set_wins", rv, 32'h1);
        csr_write(A_MASK, 32'hFFFF_FFF4);
        csr_read(A_MASK, rv); sb("t6_mask_trunc", rv, 32'h4);
        csr_write(A_EPC, 32'h1234);
        sb("t6_epc_wr", epc, 32'h1234);
        sb("t6_rd_idle", csr_rdata, 32'h0);

        for (int i = 0; i < 8; i++) begin
            pc         = 32'($urandom_range(0, 32'h7FFF_FFFF)) & 32'hFFFF_FFFC;
            pc_next_in = 32'($urandom_range(0, 32'h7FFF_FFFF)) & 32'hFFFF_FFFC;
            #1;
            sb("rand_pc_pass", pc_out, pc_next_in);
            tick();
        end

        // Take beats a same-cycle EPC write
        pc = 32'h2FC; pc_next_in = 32'h300;
        csr_write(A_MASK, 32'h1);
        csr_wr = 1'b1; csr_addr = A_EPC; csr_wdata = 32'hDEAD;
        #1;
        sb("t6_take_vec", pc_out, IRQ_VEC);
        push_exp(32'h300);
        tick();
        csr_wr = 1'b0; csr_addr = '0; csr_wdata = '0;
        pop_check("t6_take_wins", epc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_exc_ctrl.md
# irq_exc_ctrl

Parametrised interrupt/exception controller for the single-cycle MIPS core. It replaces the hard-wired `Interrupt`/`Exception` OR-ing and the fixed vector select with N maskable, edge-latched interrupt channels and prioritised exception causes. It also holds EPC/CAUSE state, a handler state machine and double-fault halting. It sits beside the PC register. The core loads `pc_out` every cycle, and the controller is accessed as a small memory-mapped CSR block.

## Interface
- NUM_IRQ, 4, interrupt channels (1..16)
- NUM_EXC, 3, external exception sources
- IRQ_VEC, 32'h80000004, interrupt entry address
- EXC_VEC, 32'h80000008, exception entry address
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- pc  in  32  address of instruction executing this cycle
- pc_next_in  in  32  core-computed next PC
- irq_in  in  NUM_IRQ  synchronous interrupt requests; rising edge latches pending
- exc_in  in  NUM_EXC  exception sources, valid this cycle: bit0 ALU overflow, bit1 illegal opcode, bit2 fetch out of range
- eret  in  1  decoder flags return-from-handler (`jr $26` while in HANDLER)
- csr_rd, csr_wr  in  1  CSR access strobes
- csr_addr  in  2  0 MASK, 1 PENDING, 2 CAUSE, 3 EPC
- csr_wdata  in  32  write data
- csr_rdata  out  32  read data, combinational; 0 when csr_rd=0
- pc_out  out  32  PC the core loads on the next edge
- epc  out  32  current EPC, for the core to write into $26
- in_handler  out  1  state==HANDLER
- halted  out  1  state==HALT

## Operation
- States:
  - RUN (reset).
  - HANDLER: entered by any take.
  - HALT: exit only by reset.
- pending[i] is set on an irq_in[i] 0→1 edge. Previous irq_in is registered and resets to 0.
- pending[i] is cleared on take of channel i or by a CSR PENDING write-1-to-clear.
- If a new edge coincides with a clear of the same bit, set wins.
- Privilege violation (code 4): pc[31]==0 && pc_next_in[31]==1 && state==RUN.
- Exception request: |exc_in or privilege violation.
- Interrupt request: state==RUN && |(pending & MASK) && !shadow.
- Priority:
  - exception over interrupt;
  - lowest exc_in index first, privilege violation last;
  - lowest IRQ channel first.
- Exception take in RUN:
  - pc_out=EXC_VEC; EPC←pc (faulting instruction);
  - CAUSE←{1'b1, code}, codes 1/2/3/4 for exc_in bits 0/1/2 and privilege;
  - state→HANDLER.
- Interrupt take:
  - pc_out=IRQ_VEC; EPC←pc_next_in (resume point);
  - CAUSE←{1'b0, channel index in [12:8], code 0};
  - clear that pending bit; state→HANDLER.
- Exception in HANDLER (double fault): state→HALT, CAUSE code 5. While halted, pc_out=pc and no pending bits are cleared.
- eret in HANDLER: pc_out=EPC; state→RUN; shadow←1 for exactly one cycle, guaranteeing one user instruction before the next interrupt.
- eret outside HANDLER is ignored.
- Otherwise pc_out=pc_next_in.
- CSR writes:
  - MASK: low NUM_IRQ bits.
  - EPC: full 32 bits.
  - CAUSE: read-only.
  - A CSR write in the same cycle as a take loses to the take for EPC/CAUSE.
- CSR reads return MASK/PENDING zero-extended.

## Timing
- Reset values:
  - state=RUN; pending, MASK, EPC, CAUSE, shadow = 0.
  - pc_out follows pc_next_in (0 when the core's PC is at reset).
  - halted=0; in_handler=0.
- Take decision and pc_out are combinational in the request cycle. EPC, CAUSE, state and pending update on the same edge as the core's PC.
- An irq_in edge seen at edge k makes pending visible in cycle k+1; the earliest vector load is at edge k+1.
- Reset asserted mid-handler discards EPC, CAUSE and pending immediately.

## Structure
- Package irq_exc_pkg: state enum (RUN, HANDLER, HALT), cause codes 0–5, CSR addresses, vector defaults.
- Sub-module irq_prio_enc: parametrised lowest-index-first priority encoder with valid flag. It is instantiated for both IRQ and exception selection.
- Index width is $clog2(NUM_IRQ), minimum 1.

## Test plan
- MASK=4'b0110, pulse irq_in[2] at pc_next_in=0x100 → one cycle later pc_out=0x80000004, EPC=0x100, CAUSE[12:8]=2, pending[2]=0.
- irq_in[1] and irq_in[3] rise together, MASK=all → channel 1 taken. After eret, one instruction runs, then channel 3 is taken.
- exc_in[0] asserted together with an enabled pending IRQ at pc=0x40 → pc_out=0x80000008, EPC=0x40, CAUSE={1,code1}, IRQ stays pending.
- pc=0x20 with pc_next_in=0x80000010 in RUN → exception code 4. The same transition while in HANDLER → no exception.
- exc_in[1] while in HANDLER → halted=1, pc_out holds pc, CAUSE code 5. Deasserting reset recovers to RUN with all registers 0.
- CSR PENDING write of 4'b1111 in the same cycle as a new irq_in[0] edge → pending=4'b0001; MASK read-back equals the written low NUM_IRQ bits.
